// File: rtl/imm_encoder_if.sv
// Request/response bundle for the RISC-V instruction encoder.
// slave = encoder side, master = producer/consumer side.
interface imm_encoder_if #(
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [6:0]       op_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      imm_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] err_count_o;

    modport slave (
        input  in_valid_i,
        input  op_i,
        input  rd_i,
        input  rs1_i,
        input  rs2_i,
        input  funct3_i,
        input  funct7_i,
        input  imm_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output instr_o,
        output err_o,
        output err_count_o
    );

    modport master (
        output in_valid_i,
        output op_i,
        output rd_i,
        output rs1_i,
        output rs2_i,
        output funct3_i,
        output funct7_i,
        output imm_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  instr_o,
        input  err_o,
        input  err_count_o
    );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder: packs fields and immediate
// into a 32-bit word, flagging immediates the format cannot hold.
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    imm_encoder_if.slave  bus
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_U,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_X
    } fmt_e;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;

    logic        s1_valid_q;
    fmt_e        s1_fmt_q;
    logic        s1_err_q;
    logic [6:0]  s1_op_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [31:0] s1_imm_q;

    logic             s2_valid_q;
    logic [31:0]      s2_instr_q;
    logic             s2_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    fmt_e        fmt_d;
    logic        err_d;
    logic [31:0] word_d;

    logic s2_adv;
    logic s1_adv;
    logic in_ready;
    logic out_xfer;

    // An immediate fits a signed field iff all bits above it match its sign.
    logic fit12;
    logic fit13;
    logic fit20;
    logic fit21;

    assign fit12 = (&bus.imm_i[31:11]) | ~(|bus.imm_i[31:11]);
    assign fit13 = (&bus.imm_i[31:12]) | ~(|bus.imm_i[31:12]);
    assign fit20 = (&bus.imm_i[31:19]) | ~(|bus.imm_i[31:19]);
    assign fit21 = (&bus.imm_i[31:20]) | ~(|bus.imm_i[31:20]);

    always_comb begin
        fmt_d = FMT_X;
        err_d = 1'b1;
        unique case (bus.op_i)
            OP_R: begin
                fmt_d = FMT_R;
                err_d = 1'b0;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_d = FMT_I;
                err_d = ~fit12;
            end
            OP_LUI: begin
                fmt_d = FMT_U;
                err_d = ~fit20;
            end
            OP_STORE: begin
                fmt_d = FMT_S;
                err_d = ~fit12;
            end
            OP_BR: begin
                fmt_d = FMT_B;
                err_d = ~fit13 | bus.imm_i[0];
            end
            OP_JAL: begin
                fmt_d = FMT_J;
                err_d = ~fit21 | bus.imm_i[0];
            end
            default: begin
                fmt_d = FMT_X;
                err_d = 1'b1;
            end
        endcase
    end

    // Unsupported opcodes fall back to the R layout.
    always_comb begin
        word_d = {s1_f7_q, s1_rs2_q, s1_rs1_q,
                  s1_f3_q, s1_rd_q, s1_op_q};
        unique case (s1_fmt_q)
            FMT_I: word_d = {s1_imm_q[11:0], s1_rs1_q,
                             s1_f3_q, s1_rd_q, s1_op_q};
            FMT_U: word_d = {s1_imm_q[19:0], s1_rd_q, s1_op_q};
            FMT_S: word_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q,
                             s1_f3_q, s1_imm_q[4:0], s1_op_q};
            FMT_B: word_d = {s1_imm_q[12], s1_imm_q[10:5],
                             s1_rs2_q, s1_rs1_q, s1_f3_q,
                             s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
            FMT_J: word_d = {s1_imm_q[20], s1_imm_q[10:1],
                             s1_imm_q[11], s1_imm_q[19:12],
                             s1_rd_q, s1_op_q};
            default: ;
        endcase
    end

    assign s2_adv   = ~s2_valid_q | bus.out_ready_i;
    assign s1_adv   = s2_adv;
    assign in_ready = ~s1_valid_q | s1_adv;
    assign out_xfer = s2_valid_q & bus.out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && s2_err_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FMT_R;
            s1_err_q   <= 1'b0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_imm_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_fmt_q <= fmt_d;
                s1_err_q <= err_d;
                s1_op_q  <= bus.op_i;
                s1_rd_q  <= bus.rd_i;
                s1_rs1_q <= bus.rs1_i;
                s1_rs2_q <= bus.rs2_i;
                s1_f3_q  <= bus.funct3_i;
                s1_f7_q  <= bus.funct7_i;
                s1_imm_q <= bus.imm_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_instr_q <= word_d;
                    s2_err_q   <= s1_err_q;
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.instr_o     = s2_instr_q;
    assign bus.err_o       = s2_err_q;
    assign bus.err_count_o = cnt_q;

endmodule
